// File: rtl/fifo_seq.sv
// rtl/fifo_seq.sv - reset sequencer and valid/ready adapter for a one-cycle-latency block-RAM FIFO
module fifo_seq #(
  parameter int WIDTH     = 9,
  parameter int RST_CYC   = 5,
  parameter int GUARD_CYC = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic             init_done,
  output logic             err,
  output logic             fifo_rst,
  output logic             fifo_wr_en,
  output logic [WIDTH-1:0] fifo_din,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  input  logic             fifo_wrerr,
  input  logic             fifo_rderr
);

  localparam int CNT_MAX = (RST_CYC > GUARD_CYC) ? RST_CYC : GUARD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_GUARD = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_fifo_rst;
  logic               w_run;

  logic [1:0]         r_occ;
  logic               r_pend;
  logic [WIDTH-1:0]   r_buf0;
  logic [WIDTH-1:0]   r_buf1;
  logic               r_err;
  logic               w_pop;
  logic [2:0]         w_level;
  logic               w_rd_ok;

  // Reset/guard/run sequencing: next state and counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RESET: begin
        if (r_cnt == CNT_W'(RST_CYC - 1)) begin
          w_state_nxt = ST_GUARD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_GUARD: begin
        if (r_cnt == CNT_W'(GUARD_CYC - 1)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RESET;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State register; fifo_rst is registered so the primitive sees a clean level
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ST_RESET;
      r_cnt      <= '0;
      r_fifo_rst <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fifo_rst <= (w_state_nxt == ST_RESET);
    end
  end

  assign w_run     = (r_state == ST_RUN);
  assign init_done = w_run;
  assign fifo_rst  = r_fifo_rst;

  // Write side is a direct pass-through gated by RUN and the primitive's full flag
  assign s_ready    = w_run & ~fifo_full;
  assign fifo_wr_en = s_valid & s_ready;
  assign fifo_din   = s_data;

  // A read is only issued if its word is guaranteed a skid slot when it lands
  assign w_pop      = (r_occ != 2'd0) & m_ready;
  assign w_level    = {1'b0, r_occ} + {2'b00, r_pend};
  assign w_rd_ok    = (w_level < (3'd2 + {2'b00, w_pop}));
  assign fifo_rd_en = w_run & ~fifo_empty & w_rd_ok;

  // Skid buffer: buf0 is the head, buf1 the second entry; pend marks a word landing this cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_occ  <= 2'd0;
      r_pend <= 1'b0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      r_pend <= fifo_rd_en;
      case ({r_pend, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_buf0 <= fifo_dout;
          else               r_buf1 <= fifo_dout;
          if (r_occ != 2'd2) r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          if (r_occ == 2'd2) r_buf0 <= r_buf1;
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd2) begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo_dout;
          end else begin
            r_buf0 <= fifo_dout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign m_valid = (r_occ != 2'd0);
  assign m_data  = r_buf0;

  // Sticky error: primitive reports only count once the sequence is in RUN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (w_run && (fifo_wrerr || fifo_rderr)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

endmodule
